mux_scan_sequencer: RTL

Sequencer that sits directly upstream of the structural 4:1 multiplexer. It drives the multiplexer's address0/address1 selects to scan channels 0..3 in turn and waits a settle time for the gate-level mux to resolve. It then samples the mux output back and assembles a 4-bit snapshot (bit i = value of in_i). Each snapshot is handed downstream over a valid/ready handshake, as a single-shot or continuous scan.

---
 rtl/mux_scan_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
//
// Purpose:
//   Drives the select lines of the structural 4:1 mux so that it scans channels
//   0..3 in order. Each channel address is held for SETTLE_CYCLES cycles so the
//   gate-level mux can resolve, and mux_out is sampled in the last of those
//   cycles. The four samples form a 4-bit snapshot (bit i = in_i), which is
//   offered downstream over a valid/ready handshake. A scan can be single-shot
//   (start) or continuous (continuous held high).
//
// Parameters:
//   SETTLE_CYCLES  cycles each address is held before sampling (1..255)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   start       in   one-shot scan request, honoured only in IDLE
//   continuous  in   level; restarts a scan after each accepted snapshot
//   address0    out  mux select MSB (channel = {address0,address1})
//   address1    out  mux select LSB
//   mux_out     in   output of the 4:1 mux
//   snapshot    out  captured word, stable while snap_valid
//   snap_valid  out  snapshot available
//   snap_ready  in   downstream accepts snapshot
//   busy        out  high whenever the sequencer is not idle
//   changed     out  snapshot differs from the previously accepted one
//                    (only when MUXSEQ_CHANGE_DETECT_EN is defined)
//
// Build option:
//   MUXSEQ_CHANGE_DETECT_EN  adds the changed output and its prev register
//
// States:
//   IDLE   | waiting for start or continuous
//   SETTLE | holding a channel address, sampling mux_out when counter hits 0
//   HOLD   | snapshot presented with snap_valid, waiting for snap_ready
// -----------------------------------------------------------------------------
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       continuous,
  output logic       address0,
  output logic       address1,
  input  logic       mux_out,
  output logic [3:0] snapshot,
  output logic       snap_valid,
  input  logic       snap_ready,
  output logic       busy
`ifdef MUXSEQ_CHANGE_DETECT_EN
  ,
  output logic       changed
`endif
);

  localparam logic [7:0] LP_RELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_ch;
  logic [7:0] r_cnt;
  // Channel 3 goes straight into the snapshot, so only 0..2 need holding.
  logic [2:0] r_capture;
  logic [3:0] r_snapshot;
  logic       r_snap_valid;
  logic       r_busy;
  logic [3:0] w_new_snap;

`ifdef MUXSEQ_CHANGE_DETECT_EN
  logic [3:0] r_prev;
  logic       r_changed;
`endif

  assign w_new_snap = {mux_out, r_capture};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ch         <= 2'd0;
      r_cnt        <= 8'd0;
      r_capture    <= 3'b000;
      r_snapshot   <= 4'b0000;
      r_snap_valid <= 1'b0;
      r_busy       <= 1'b0;
`ifdef MUXSEQ_CHANGE_DETECT_EN
      r_prev       <= 4'b0000;
      r_changed    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start || continuous) begin
            r_state <= ST_SETTLE;
            r_ch    <= 2'd0;
            r_cnt   <= LP_RELOAD;
            r_busy  <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (r_ch != 2'd3) begin
            case (r_ch)
              2'd0:    r_capture[0] <= mux_out;
              2'd1:    r_capture[1] <= mux_out;
              default: r_capture[2] <= mux_out;
            endcase
            r_ch  <= r_ch + 2'd1;
            r_cnt <= LP_RELOAD;
          end else begin
            // Last channel: assemble the word and park the mux on channel 0.
            r_snapshot   <= w_new_snap;
            r_ch         <= 2'd0;
            r_snap_valid <= 1'b1;
            r_state      <= ST_HOLD;
`ifdef MUXSEQ_CHANGE_DETECT_EN
            r_changed    <= (w_new_snap != r_prev);
`endif
          end
        end

        ST_HOLD: begin
          if (snap_ready) begin
            r_snap_valid <= 1'b0;
`ifdef MUXSEQ_CHANGE_DETECT_EN
            r_prev       <= r_snapshot;
`endif
            if (continuous) begin
              r_state <= ST_SETTLE;
              r_ch    <= 2'd0;
              r_cnt   <= LP_RELOAD;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_ch         <= 2'd0;
          r_cnt        <= 8'd0;
          r_snap_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign address0   = r_ch[1];
  assign address1   = r_ch[0];
  assign snapshot   = r_snapshot;
  assign snap_valid = r_snap_valid;
  assign busy       = r_busy;
`ifdef MUXSEQ_CHANGE_DETECT_EN
  assign changed    = r_changed;
`endif

endmodule
